// File: rtl/ext_flicker_endpoint.sv
// ---------------------------------------------------------------------------
// ext_flicker_endpoint
//
// External-side peer of the PULPino toggle ("flicker") byte channel. Each
// direction uses a data byte plus a write flicker (toggled by the sender to
// announce a byte) and a read flicker (toggled by the receiver to ack it).
//
//  RX path : bytes announced by PULPino are captured into a small FIFO and
//            acked by toggling ep_read_flicker_o. When the FIFO is full the
//            ack is withheld, so PULPino simply holds its byte.
//  TX path : a three-state FSM (SYNC -> IDLE -> WAIT -> IDLE) drives
//            ep_data_o, toggles ep_write_flicker_o and waits for PULPino's
//            read flicker, with an optional ack timeout.
//
// Ports
//  clk, rst_n            : clock (pulpino_clk) and synchronous active-low reset
//  peer_data_i           : byte from PULPino
//  peer_write_flicker_i  : PULPino announces peer_data_i
//  peer_read_flicker_i   : PULPino acks ep_data_o
//  ep_data_o             : byte to PULPino
//  ep_write_flicker_o    : announces ep_data_o
//  ep_read_flicker_o     : acks a captured peer byte
//  rx_data_o/rx_valid_o  : FIFO head and not-empty flag (registered)
//  rx_ready_i            : pops the head when rx_valid_o is high
//  rx_count_o            : FIFO occupancy 0..pFIFO_DEPTH (registered)
//  tx_data_i/tx_valid_i  : byte to send and send request
//  tx_ready_o            : TX FSM idle, a request is accepted
//  tx_timeout_o          : sticky flag, a TX ack timed out
//  clear_timeout_i       : clears tx_timeout_o
// ---------------------------------------------------------------------------
module ext_flicker_endpoint #(
   parameter int pFIFO_DEPTH = 4,
   parameter int pCNT_WIDTH  = 3,
   parameter int pTIMEOUT    = 1024
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [7:0]            peer_data_i,
   input  logic                  peer_write_flicker_i,
   input  logic                  peer_read_flicker_i,
   output logic [7:0]            ep_data_o,
   output logic                  ep_write_flicker_o,
   output logic                  ep_read_flicker_o,
   output logic [7:0]            rx_data_o,
   output logic                  rx_valid_o,
   input  logic                  rx_ready_i,
   output logic [pCNT_WIDTH-1:0] rx_count_o,
   input  logic [7:0]            tx_data_i,
   input  logic                  tx_valid_i,
   output logic                  tx_ready_o,
   output logic                  tx_timeout_o,
   input  logic                  clear_timeout_i
);

   localparam int pPTR_W = (pFIFO_DEPTH > 1) ? $clog2(pFIFO_DEPTH) : 1;
   localparam int pTMR_W = (pTIMEOUT > 1) ? $clog2(pTIMEOUT) : 1;

   localparam logic [pCNT_WIDTH-1:0] cFIFO_FULL = pCNT_WIDTH'(pFIFO_DEPTH);
   localparam logic [pTMR_W-1:0]     cTMR_LAST  = pTMR_W'(pTIMEOUT - 1);
   localparam logic [pTMR_W-1:0]     cTMR_MAX   = '1;

   typedef enum logic [1:0] {
      TX_SYNC,
      TX_IDLE,
      TX_WAIT
   } tx_state_t;

   tx_state_t state_q;
   tx_state_t state_d;

   // Last flicker levels already consumed; a difference means a new event
   logic wr_seen;
   logic rd_seen;

   logic [7:0]        fifo_mem [pFIFO_DEPTH];
   logic [pPTR_W-1:0] wr_ptr;
   logic [pPTR_W-1:0] rd_ptr;
   logic [pPTR_W-1:0] rd_ptr_next;
   logic [pCNT_WIDTH-1:0] count_next;
   logic [7:0]        head_next;

   logic [pTMR_W-1:0] timer;

   logic in_sync;
   logic rx_pop;
   logic rx_full;
   logic rx_push;
   logic rd_event;
   logic tx_accept;
   logic tx_ack;
   logic tx_expire;

   // Event decoding for both paths. In SYNC the flicker levels are only
   // being learned, so nothing counts as an event yet.
   always_comb begin
      in_sync   = (state_q == TX_SYNC);
      rx_pop    = rx_valid_o && rx_ready_i;
      rx_full   = (rx_count_o == cFIFO_FULL);
      rx_push   = !in_sync && (peer_write_flicker_i != wr_seen) && (!rx_full || rx_pop);
      rd_event  = (peer_read_flicker_i != rd_seen);
      tx_accept = (state_q == TX_IDLE) && tx_valid_i;
      tx_ack    = (state_q == TX_WAIT) && rd_event;
      tx_expire = (state_q == TX_WAIT) && !rd_event && (pTIMEOUT != 0) && (timer == cTMR_LAST);
   end

   // Next FIFO state. The head register must show the incoming byte when it
   // lands directly at the head slot (empty FIFO, or the last entry popped
   // in the same cycle), because the memory write is not visible yet.
   always_comb begin
      rd_ptr_next = rx_pop ? rd_ptr + 1'b1 : rd_ptr;
      count_next  = rx_count_o;
      case ({rx_push, rx_pop})
         2'b10:   count_next = rx_count_o + 1'b1;
         2'b01:   count_next = rx_count_o - 1'b1;
         default: count_next = rx_count_o;
      endcase
      if (rx_push && (rd_ptr_next == wr_ptr)) begin
         head_next = peer_data_i;
      end else begin
         head_next = fifo_mem[rd_ptr_next];
      end
   end

   // FIFO storage needs no reset; the pointers define what is valid
   always_ff @(posedge clk) begin
      if (rx_push) begin
         fifo_mem[wr_ptr] <= peer_data_i;
      end
   end

   // FIFO pointers, registered RX outputs and the RX ack flicker
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr            <= '0;
         rd_ptr            <= '0;
         rx_count_o        <= '0;
         rx_valid_o        <= 1'b0;
         rx_data_o         <= 8'h00;
         ep_read_flicker_o <= 1'b0;
      end else begin
         if (rx_push) begin
            wr_ptr            <= wr_ptr + 1'b1;
            ep_read_flicker_o <= !ep_read_flicker_o;
         end
         rd_ptr     <= rd_ptr_next;
         rx_count_o <= count_next;
         rx_valid_o <= (count_next != '0);
         rx_data_o  <= head_next;
      end
   end

   // Seen-levels of the peer flickers. While IDLE the read flicker is
   // tracked every cycle so late or stray acks never complete a new send.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_seen <= 1'b0;
         rd_seen <= 1'b0;
      end else if (in_sync) begin
         wr_seen <= peer_write_flicker_i;
         rd_seen <= peer_read_flicker_i;
      end else begin
         if (rx_push) begin
            wr_seen <= peer_write_flicker_i;
         end
         if ((state_q == TX_IDLE) || tx_ack) begin
            rd_seen <= peer_read_flicker_i;
         end
      end
   end

   // TX FSM state register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= TX_SYNC;
      end else begin
         state_q <= state_d;
      end
   end

   // TX FSM next state; an ack beats a timeout in the same cycle
   always_comb begin
      state_d = state_q;
      case (state_q)
         TX_SYNC: state_d = TX_IDLE;
         TX_IDLE: if (tx_valid_i) state_d = TX_WAIT;
         TX_WAIT: if (tx_ack || tx_expire) state_d = TX_IDLE;
         default: state_d = TX_SYNC;
      endcase
   end

   // TX FSM outputs
   always_comb begin
      tx_ready_o = (state_q == TX_IDLE);
   end

   // TX datapath: data/flicker on accept, saturating ack timer, sticky
   // timeout flag where a new timeout beats a simultaneous clear
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ep_data_o          <= 8'h00;
         ep_write_flicker_o <= 1'b0;
         timer              <= '0;
         tx_timeout_o       <= 1'b0;
      end else begin
         if (tx_accept) begin
            ep_data_o          <= tx_data_i;
            ep_write_flicker_o <= !ep_write_flicker_o;
            timer              <= '0;
         end else if ((state_q == TX_WAIT) && !rd_event && !tx_expire && (timer != cTMR_MAX)) begin
            timer <= timer + 1'b1;
         end
         if (tx_expire) begin
            tx_timeout_o <= 1'b1;
         end else if (clear_timeout_i) begin
            tx_timeout_o <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_ext_flicker_endpoint.sv
// ---------------------------------------------------------------------------
// tb_ext_flicker_endpoint
//
// Drives ext_flicker_endpoint (depth 4, timeout 8) with directed sequences
// acting as the PULPino side. A transaction-level model (byte queue plus
// flicker/ack bookkeeping) predicts every output and is compared on each
// falling edge; hand-computed literal checks pin the model at key points.
// ---------------------------------------------------------------------------
module tb_ext_flicker_endpoint;

   localparam int DEPTH   = 4;
   localparam int TIMEOUT = 8;

   logic       clk;
   logic       rst_n;
   logic [7:0] peer_data;
   logic       peer_w;
   logic       peer_r;
   logic [7:0] ep_data_o;
   logic       ep_write_flicker_o;
   logic       ep_read_flicker_o;
   logic [7:0] rx_data_o;
   logic       rx_valid_o;
   logic       rx_ready;
   logic [2:0] rx_count_o;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready_o;
   logic       tx_timeout_o;
   logic       clear_timeout;

   int errors = 0;
   int checks = 0;

   // Model state
   logic [7:0] q [$];
   logic       m_rflk;
   logic       m_wflk;
   logic [7:0] m_data;
   logic       m_timeout;
   logic       m_synced;
   logic       m_busy;
   logic       m_wseen;
   logic       m_rseen;
   int         m_waited;
   logic       m_valid = 1'b0;

   logic       exp_rflk;

   ext_flicker_endpoint #(
      .pFIFO_DEPTH(DEPTH),
      .pCNT_WIDTH (3),
      .pTIMEOUT   (TIMEOUT)
   ) dut (
      .clk                 (clk),
      .rst_n               (rst_n),
      .peer_data_i         (peer_data),
      .peer_write_flicker_i(peer_w),
      .peer_read_flicker_i (peer_r),
      .ep_data_o           (ep_data_o),
      .ep_write_flicker_o  (ep_write_flicker_o),
      .ep_read_flicker_o   (ep_read_flicker_o),
      .rx_data_o           (rx_data_o),
      .rx_valid_o          (rx_valid_o),
      .rx_ready_i          (rx_ready),
      .rx_count_o          (rx_count_o),
      .tx_data_i           (tx_data),
      .tx_valid_i          (tx_valid),
      .tx_ready_o          (tx_ready_o),
      .tx_timeout_o        (tx_timeout_o),
      .clear_timeout_i     (clear_timeout)
   );

   // Free-running clock, first rising edge at 5
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
      end
   endtask

   // Advance n rising edges and step just past the last one
   task automatic applyStimulus(input int cycles);
      repeat (cycles) @(posedge clk);
      #1;
   endtask

   // Transaction-level model, evaluated on every rising edge from the
   // inputs the bench holds stable across that edge
   initial begin
      logic popping;
      logic accept;
      logic expired;
      forever begin
         @(posedge clk);
         if (!rst_n) begin
            q.delete();
            m_rflk    = 1'b0;
            m_wflk    = 1'b0;
            m_data    = 8'h00;
            m_timeout = 1'b0;
            m_synced  = 1'b0;
            m_busy    = 1'b0;
            m_wseen   = 1'b0;
            m_rseen   = 1'b0;
            m_waited  = 0;
            m_valid   = 1'b1;
         end else if (!m_synced) begin
            m_synced = 1'b1;
            m_wseen  = peer_w;
            m_rseen  = peer_r;
            if (clear_timeout) m_timeout = 1'b0;
         end else begin
            popping = (q.size() != 0) && rx_ready;
            accept  = (peer_w != m_wseen) && ((q.size() < DEPTH) || popping);
            if (popping) void'(q.pop_front());
            if (accept) begin
               q.push_back(peer_data);
               m_wseen = peer_w;
               m_rflk  = !m_rflk;
            end
            expired = 1'b0;
            if (!m_busy) begin
               m_rseen = peer_r;
               if (tx_valid) begin
                  m_data   = tx_data;
                  m_wflk   = !m_wflk;
                  m_waited = 0;
                  m_busy   = 1'b1;
               end
            end else if (peer_r != m_rseen) begin
               m_rseen = peer_r;
               m_busy  = 1'b0;
            end else begin
               m_waited++;
               if ((TIMEOUT != 0) && (m_waited == TIMEOUT)) begin
                  expired = 1'b1;
                  m_busy  = 1'b0;
               end
            end
            if (expired) m_timeout = 1'b1;
            else if (clear_timeout) m_timeout = 1'b0;
         end
      end
   end

   // Compare every output against the model on each falling edge
   initial begin
      forever begin
         @(negedge clk);
         if (m_valid) begin
            checkOutput("rx_valid", 32'(rx_valid_o), 32'(q.size() != 0));
            if (q.size() != 0) checkOutput("rx_data", 32'(rx_data_o), 32'(q[0]));
            checkOutput("rx_count", 32'(rx_count_o), 32'(q.size()));
            checkOutput("ep_data", 32'(ep_data_o), 32'(m_data));
            checkOutput("ep_write_flicker", 32'(ep_write_flicker_o), 32'(m_wflk));
            checkOutput("ep_read_flicker", 32'(ep_read_flicker_o), 32'(m_rflk));
            checkOutput("tx_ready", 32'(tx_ready_o), 32'(m_synced && !m_busy));
            checkOutput("tx_timeout", 32'(tx_timeout_o), 32'(m_timeout));
         end
      end
   end

   // Directed stimulus with literal expectations
   initial begin
      rst_n         = 1'b0;
      peer_data     = 8'h00;
      peer_w        = 1'b1;
      peer_r        = 1'b0;
      rx_ready      = 1'b0;
      tx_data       = 8'h00;
      tx_valid      = 1'b0;
      clear_timeout = 1'b0;
      exp_rflk      = 1'b0;

      // Reset with the write flicker high: all outputs zero
      applyStimulus(3);
      checkOutput("lit_reset_count", 32'(rx_count_o), 0);
      checkOutput("lit_reset_valid", 32'(rx_valid_o), 0);
      checkOutput("lit_reset_ready", 32'(tx_ready_o), 0);
      checkOutput("lit_reset_flickers", 32'({ep_write_flicker_o, ep_read_flicker_o}), 0);

      // Release: SYNC learns the high level, so no push follows
      rst_n = 1'b1;
      applyStimulus(2);
      checkOutput("lit_sync_count", 32'(rx_count_o), 0);
      checkOutput("lit_sync_rflk", 32'(ep_read_flicker_o), 0);
      checkOutput("lit_sync_ready", 32'(tx_ready_o), 1);

      // Single byte 0xA5
      peer_data = 8'hA5;
      peer_w    = !peer_w;
      applyStimulus(1);
      exp_rflk = !exp_rflk;
      checkOutput("lit_a5_ack", 32'(ep_read_flicker_o), 32'(exp_rflk));
      checkOutput("lit_a5_data", 32'(rx_data_o), 'hA5);
      checkOutput("lit_a5_count", 32'(rx_count_o), 1);
      rx_ready = 1'b1;
      applyStimulus(1);
      rx_ready = 1'b0;
      checkOutput("lit_a5_popped", 32'(rx_count_o), 0);

      // Fill to depth, fifth byte must wait for space
      for (int i = 1; i <= 4; i++) begin
         peer_data = 8'(i);
         peer_w    = !peer_w;
         applyStimulus(1);
         exp_rflk = !exp_rflk;
         checkOutput("lit_fill_ack", 32'(ep_read_flicker_o), 32'(exp_rflk));
      end
      peer_data = 8'h05;
      peer_w    = !peer_w;
      applyStimulus(3);
      checkOutput("lit_full_no_ack", 32'(ep_read_flicker_o), 32'(exp_rflk));
      checkOutput("lit_full_count", 32'(rx_count_o), 4);
      checkOutput("lit_full_head", 32'(rx_data_o), 'h01);
      rx_ready = 1'b1;
      applyStimulus(1);
      rx_ready = 1'b0;
      exp_rflk = !exp_rflk;
      checkOutput("lit_full_late_ack", 32'(ep_read_flicker_o), 32'(exp_rflk));
      checkOutput("lit_full_swap_count", 32'(rx_count_o), 4);
      for (int i = 2; i <= 5; i++) begin
         checkOutput("lit_drain_order", 32'(rx_data_o), 32'(i));
         rx_ready = 1'b1;
         applyStimulus(1);
         rx_ready = 1'b0;
      end
      checkOutput("lit_drain_empty", 32'(rx_valid_o), 0);

      // TX 0x3C with peer ack
      tx_data  = 8'h3C;
      tx_valid = 1'b1;
      applyStimulus(1);
      tx_valid = 1'b0;
      checkOutput("lit_tx_data", 32'(ep_data_o), 'h3C);
      checkOutput("lit_tx_wflk", 32'(ep_write_flicker_o), 1);
      checkOutput("lit_tx_busy", 32'(tx_ready_o), 0);
      applyStimulus(2);
      checkOutput("lit_tx_still_busy", 32'(tx_ready_o), 0);
      peer_r = !peer_r;
      applyStimulus(1);
      checkOutput("lit_tx_acked", 32'(tx_ready_o), 1);

      // TX timeout after 8 WAIT cycles, late ack absorbed, then clear
      tx_data  = 8'h5A;
      tx_valid = 1'b1;
      applyStimulus(1);
      tx_valid = 1'b0;
      applyStimulus(7);
      checkOutput("lit_to_not_yet", 32'(tx_timeout_o), 0);
      applyStimulus(1);
      checkOutput("lit_to_set", 32'(tx_timeout_o), 1);
      checkOutput("lit_to_idle", 32'(tx_ready_o), 1);
      peer_r = !peer_r;
      applyStimulus(1);
      checkOutput("lit_late_ack_sticky", 32'(tx_timeout_o), 1);
      clear_timeout = 1'b1;
      applyStimulus(1);
      clear_timeout = 1'b0;
      checkOutput("lit_to_cleared", 32'(tx_timeout_o), 0);

      // Full FIFO, pop + pending push + TX ack in the same cycle
      for (int i = 0; i < 4; i++) begin
         peer_data = 8'h11 + 8'(i);
         peer_w    = !peer_w;
         applyStimulus(1);
         exp_rflk = !exp_rflk;
      end
      checkOutput("lit_refill_count", 32'(rx_count_o), 4);
      tx_data  = 8'h77;
      tx_valid = 1'b1;
      applyStimulus(1);
      tx_valid = 1'b0;
      applyStimulus(1);
      checkOutput("lit_tx77_waiting", 32'(tx_ready_o), 0);
      checkOutput("lit_tx77_data", 32'(ep_data_o), 'h77);
      peer_data = 8'h15;
      peer_w    = !peer_w;
      peer_r    = !peer_r;
      rx_ready  = 1'b1;
      applyStimulus(1);
      rx_ready = 1'b0;
      exp_rflk = !exp_rflk;
      checkOutput("lit_combo_count", 32'(rx_count_o), 4);
      checkOutput("lit_combo_ack", 32'(ep_read_flicker_o), 32'(exp_rflk));
      checkOutput("lit_combo_tx_idle", 32'(tx_ready_o), 1);
      checkOutput("lit_combo_head", 32'(rx_data_o), 'h12);
      for (int i = 0; i < 4; i++) begin
         checkOutput("lit_combo_drain", 32'(rx_data_o), 32'(8'h12 + 8'(i)));
         rx_ready = 1'b1;
         applyStimulus(1);
         rx_ready = 1'b0;
      end

      // Reset in the middle of traffic abandons everything silently
      peer_data = 8'h99;
      peer_w    = !peer_w;
      applyStimulus(1);
      tx_data  = 8'h42;
      tx_valid = 1'b1;
      applyStimulus(1);
      tx_valid = 1'b0;
      rst_n    = 1'b0;
      peer_w   = !peer_w;
      applyStimulus(2);
      checkOutput("lit_midrst_count", 32'(rx_count_o), 0);
      checkOutput("lit_midrst_wflk", 32'(ep_write_flicker_o), 0);
      checkOutput("lit_midrst_data", 32'(ep_data_o), 0);
      rst_n = 1'b1;
      applyStimulus(3);
      checkOutput("lit_after_rst_count", 32'(rx_count_o), 0);
      checkOutput("lit_after_rst_ready", 32'(tx_ready_o), 1);

      applyStimulus(2);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
